// File: rtl/lcg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcg_pkg
// Description : Shared state encoding, error codes and default widths for the
//               LCG run controller.
// Revision    : 1.0 - initial release
// ============================================================================
package lcg_pkg;

    localparam int LCG_CNT_W = 12;
    localparam int LCG_SUM_W = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CLEAR  = 3'd1;
    localparam state_t ST_RUN    = 3'd2;
    localparam state_t ST_SETTLE = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_ZERO = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage : lcg_pkg
`default_nettype wire

// File: rtl/lcg_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : lcg_watchdog
// Description : Free-running run watchdog; expires when the counter is all ones.
// Revision    : 1.0 - initial release
// ============================================================================
module lcg_watchdog
    import lcg_pkg::*;
#(
    parameter int TMO_W = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = (r_cnt == '1);

endmodule : lcg_watchdog
`default_nettype wire

// File: rtl/lcg_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcg_run_ctrl
// Description : Clears and runs the LCG sum generator, captures its sum and
//               returns it on a valid/ready result port with error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module lcg_run_ctrl
    import lcg_pkg::*;
#(
    parameter int CNT_W      = LCG_CNT_W,
    parameter int SUM_W      = LCG_SUM_W,
    parameter int CLR_CYC    = 4,
    parameter int SETTLE_CYC = 4,
    parameter int TMO_W      = 20
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             LCG_sig,
    output logic [CNT_W-1:0] number,
    input  logic             lcg_ready,
    input  logic [SUM_W-1:0] lcg_sum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SUM_W-1:0] res_sum,
    output logic [1:0]       res_err
);

    localparam int c_CLR_W = $clog2(CLR_CYC + 1);
    localparam int c_SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [c_CLR_W-1:0] c_CLR_LAST = c_CLR_W'(CLR_CYC - 1);
    localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYC - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_number;
    logic [c_CLR_W-1:0] r_clr_cnt;
    logic [c_SET_W-1:0] r_set_cnt;
    logic [SUM_W-1:0]   r_res_sum;
    logic [1:0]         r_res_err;
    logic               w_zero;
    logic               w_expired;
    logic               w_wd_clr;
    logic               w_wd_en;

    assign w_zero = (count == '0);

    lcg_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (w_wd_clr),
        .en      (w_wd_en),
        .expired (w_expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = w_zero ? ST_DONE : ST_CLEAR;
                end
            end
            // A Ready left over from the previous run must fall before enabling.
            ST_CLEAR: begin
                if ((r_clr_cnt == c_CLR_LAST) && !lcg_ready) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (lcg_ready) begin
                    w_next = ST_SETTLE;
                end else if (w_expired) begin
                    w_next = ST_DONE;
                end
            end
            ST_SETTLE: begin
                if (r_set_cnt == c_SET_LAST) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != ST_IDLE);
        LCG_sig   = (r_state == ST_RUN) || (r_state == ST_SETTLE);
        res_valid = (r_state == ST_DONE);
        w_wd_en   = (r_state == ST_RUN);
        w_wd_clr  = (r_state != ST_RUN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_number  <= '0;
            r_clr_cnt <= '0;
            r_set_cnt <= '0;
            r_res_sum <= '0;
            r_res_err <= ERR_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_clr_cnt <= '0;
                    if (start) begin
                        r_number <= count;
                        if (w_zero) begin
                            r_res_sum <= '0;
                            r_res_err <= ERR_ZERO;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt != c_CLR_LAST) begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_set_cnt <= '0;
                    if (!lcg_ready && w_expired) begin
                        r_res_sum <= '0;
                        r_res_err <= ERR_TMO;
                    end
                end
                // The generator's sum trails Ready by a step, so sample late.
                ST_SETTLE: begin
                    r_set_cnt <= r_set_cnt + 1'b1;
                    if (r_set_cnt == c_SET_LAST) begin
                        r_res_sum <= lcg_sum;
                        r_res_err <= ERR_OK;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign number  = r_number;
    assign res_sum = r_res_sum;
    assign res_err = r_res_err;

endmodule : lcg_run_ctrl
`default_nettype wire
